// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types for the iterative shift-add multiplier.
// Signed operation is a build option: SEQ_MULTIPLIER_SIGNED_EN.
package seq_mult_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/done handshake and operand/product bus.
// master issues requests, slave is the multiplier.
interface seq_multiplier_if
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   multiplicand_in;
  logic [WIDTH-1:0]   multiplier_in;
  logic               signed_mode;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product_out;

  modport master (
    output start,
    output multiplicand_in,
    output multiplier_in,
    output signed_mode,
    input  busy,
    input  done,
    input  product_out
  );

  modport slave (
    input  start,
    input  multiplicand_in,
    input  multiplier_in,
    input  signed_mode,
    output busy,
    output done,
    output product_out
  );

endinterface

// File: rtl/seq_multiplier_operand_reg.sv
// operand_reg: load-enable register, synchronous active-high reset.
// Holds the multiplicand for the whole iteration.
module operand_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on load; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: one add-shift step per clock, 2*WIDTH-bit product.
// Build option SEQ_MULTIPLIER_SIGNED_EN adds two's-complement mode.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    work_q;
  logic [PW-1:0]    prod_q;
  logic             done_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    result;
  logic             accept;
  logic             last_step;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic neg_q;
  logic neg_d;
  logic a_neg;
  logic b_neg;

  // Negative operands are iterated as magnitudes; the most-negative
  // value maps onto itself, which is its correct unsigned magnitude.
  assign a_neg  = bus.signed_mode & bus.multiplicand_in[WIDTH-1];
  assign b_neg  = bus.signed_mode & bus.multiplier_in[WIDTH-1];
  assign a_op   = a_neg ? -bus.multiplicand_in : bus.multiplicand_in;
  assign b_op   = b_neg ? -bus.multiplier_in : bus.multiplier_in;
  assign neg_d  = a_neg ^ b_neg;
  assign result = neg_q ? -work_q : work_q;

  // Result sign, captured with the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_d;
    end
  end
`else
  assign a_op   = bus.multiplicand_in;
  assign b_op   = bus.multiplier_in;
  assign result = work_q;
`endif

  operand_reg #(
    .WIDTH (WIDTH)
  ) u_mcand (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .d    (a_op),
    .q    (mcand_q)
  );

  assign addend = work_q[0] ? {1'b0, mcand_q} : '0;
  assign sum    = {1'b0, work_q[PW-1:WIDTH]} + addend;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept, iterate WIDTH steps, publish, return.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_step) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working product and step counter; carry enters from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      work_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      work_q <= {{WIDTH{1'b0}}, b_op};
    end else if (state_q == CALC) begin
      cnt_q  <= cnt_q + 1'b1;
      work_q <= {sum, work_q[WIDTH-1:1]};
    end
  end

  // Published product and one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FINISH);
      if (state_q == FINISH) prod_q <= result;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = done_q;
  assign bus.product_out = prod_q;

endmodule
